sevenseg_scan_driver: RTL and testbench



---
 rtl/sevenseg_scan_driver_if.sv | 24 ++
 rtl/sevenseg_scan_driver.sv | 154 +++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_driver_if.sv
// Datapath-facing bundle of the seven-segment scan driver: display request in,
// board pin levels and frame marker out.
interface sevenseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic                    load;
  logic [7:0]              segments;
  logic [NUM_DIGITS-1:0]   anodes;
  logic                    frame_start;

  modport master (
    output value, dp_en, digit_en, lz_blank, load,
    input  segments, anodes, frame_start
  );

  modport slave (
    input  value, dp_en, digit_en, lz_blank, load,
    output segments, anodes, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit hex display driver with double-buffered loading,
// leading-zero blanking, per-digit enables and anti-ghosting blank time.

// One digit's glyph: hex decode, leading-zero suppression and the "still worth
// lighting" flag (a blanked digit stays lit only to show its dot).
module sevenseg_digit #(
  parameter bit LZ_OK = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       tail_zero,
  input  logic       lz_blank,
  output logic [7:0] seg,
  output logic       lit
);
  logic [6:0] glyph;
  logic       blank;

  always_comb begin
    glyph = 7'b0000000;
    case (nib)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1110011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      4'hF: glyph = 7'b1000111;
      default: glyph = 7'b0000000;
    endcase
  end

  assign blank = LZ_OK && lz_blank && tail_zero;
  assign seg   = {(blank ? 7'b0000000 : glyph), dp};
  assign lit   = !blank || dp;
endmodule

module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sevenseg_scan_driver_if.slave    bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]         CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] val;
    logic [NUM_DIGITS-1:0]      dp;
  } disp_buf_t;

  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  disp_buf_t                  act, pend_buf, in_buf;
  logic                       pend;
  logic                       last_cnt, wrap;
  logic [7:0]                 seg_q, seg_nx;
  logic [NUM_DIGITS-1:0]      an_q, an_nx;
  logic                       fs_q;
  logic [NUM_DIGITS-1:0]      tail_zero;
  logic [NUM_DIGITS-1:0][7:0] dig_seg;
  logic [NUM_DIGITS-1:0]      dig_lit;

  assign in_buf   = {bus.value, bus.dp_en};
  assign last_cnt = (cnt == CNT_MAX);
  assign wrap     = last_cnt && (idx == IDX_MAX);

  // tail_zero[i]: active nibbles i..NUM_DIGITS-1 are all zero
  always_comb begin
    logic z;
    z         = 1'b1;
    tail_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z            = z && (act.val[i] == 4'h0);
      tail_zero[i] = z;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    sevenseg_digit #(.LZ_OK(i != 0)) u_dig (
      .nib       (act.val[i]),
      .dp        (act.dp[i]),
      .tail_zero (tail_zero[i]),
      .lz_blank  (bus.lz_blank),
      .seg       (dig_seg[i]),
      .lit       (dig_lit[i])
    );
  end

  // Active-high view of the next pin state; polarity is applied at the register.
  always_comb begin
    seg_nx = '0;
    an_nx  = '0;
    if (cnt >= BLANK_END) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IW'(i)) begin
          seg_nx   = dig_seg[i];
          an_nx[i] = dig_lit[i] && bus.digit_en[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      act      <= '0;
      pend_buf <= '0;
      pend     <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      fs_q     <= 1'b0;
    end else begin
      cnt <= last_cnt ? '0 : cnt + CW'(1);
      if (last_cnt) idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      // Active only changes at the frame boundary so a frame never mixes values.
      if (wrap) begin
        if (bus.load)  act <= in_buf;
        else if (pend) act <= pend_buf;
        pend <= 1'b0;
      end else if (bus.load) begin
        pend_buf <= in_buf;
        pend     <= 1'b1;
      end
      seg_q <= seg_nx ^ SEG_OFF;
      an_q  <= an_nx ^ AN_OFF;
      fs_q  <= wrap;
    end
  end

  assign bus.segments    = seg_q;
  assign bus.anodes      = an_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomized and directed bench for sevenseg_scan_driver against a cycle-count
// based reference model.
module tb_sevenseg_scan_driver;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 1;
  localparam int FR = ND * RD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // model: k = clock edges since reset release; shown/pending buffers
  int          k = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
  bit          m_pend_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [7:0] es;
    logic [3:0] ea;
    logic       ef;
    int         cnt, idx;
    logic [3:0] nib;
    bit         lz, dot;
    @(posedge clk);
    es = 8'hFF;
    ea = 4'hF;
    ef = 1'b0;
    if (!rst_n) begin
      k = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pend_v = 1'b0;
    end else begin
      cnt = k % RD;
      idx = (k / RD) % ND;
      ef  = ((k % FR) == FR - 1);
      if (cnt >= BC) begin
        nib = m_act[4*idx +: 4];
        dot = m_act_dp[idx];
        lz  = bus.lz_blank && idx > 0 && ((m_act >> (4 * idx)) == 16'h0);
        es  = ~{(lz ? 7'b0000000 : glyph_tab[nib]), dot};
        if (bus.digit_en[idx] && (!lz || dot)) ea = ~(4'b0001 << idx);
      end
      if (ef) begin
        if (bus.load) begin
          m_act = bus.value; m_act_dp = bus.dp_en;
        end else if (m_pend_v) begin
          m_act = m_pend; m_act_dp = m_pend_dp;
        end
        m_pend_v = 1'b0;
      end else if (bus.load) begin
        m_pend = bus.value; m_pend_dp = bus.dp_en; m_pend_v = 1'b1;
      end
      k++;
    end
    #1;
    chk("segments", {24'h0, bus.segments}, {24'h0, es});
    chk("anodes", {28'h0, bus.anodes}, {28'h0, ea});
    chk("frame_start", {31'h0, bus.frame_start}, {31'h0, ef});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // advance until the next edge will process scan phase ph (bounded by one frame)
  task automatic goto_phase(input int ph);
    for (int g = 0; g < FR && (k % FR) != ph; g++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus.value = v; bus.dp_en = d; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  logic [7:0] dec_12af [4] = '{8'b01110001, 8'b00010001, 8'b00100101, 8'b10011111};
  int fs_seen;

  initial begin
    bus.value = '0; bus.dp_en = '0; bus.digit_en = 4'hF; bus.lz_blank = 1'b0; bus.load = 1'b0;
    rst_n = 1'b0;
    run(3);
    chk("rst_anodes", {28'h0, bus.anodes}, 32'hF);
    chk("rst_segments", {24'h0, bus.segments}, 32'hFF);
    rst_n = 1'b1;
    run(3);

    // decode of 12AF, checked against literal pin patterns too
    do_load(16'h12AF, 4'h0);
    run(2 * FR);
    for (int d = 0; d < ND; d++) begin
      goto_phase(d * RD + 3);
      tick();
      chk("dec12af_seg", {24'h0, bus.segments}, {24'h0, dec_12af[d]});
    end
    fs_seen = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (bus.frame_start) fs_seen++;
    end
    chk("fs_per_64", fs_seen, 2);

    // tear-free: 1111 loaded on wrap, 2222 loaded during digit 2
    goto_phase(FR - 1);
    do_load(16'h1111, 4'h0);
    run(FR - 1);
    goto_phase(2 * RD + 2);
    do_load(16'h2222, 4'h0);
    run(2 * FR);

    // two loads in one frame: only the second survives
    goto_phase(RD);
    do_load(16'h3333, 4'h1);
    run(5);
    do_load(16'h4444, 4'h2);
    run(2 * FR);

    // leading-zero blanking with dot on the blanked top digit
    bus.lz_blank = 1'b1;
    do_load(16'h0070, 4'b1000);
    run(2 * FR);
    goto_phase(3 * RD + 4);
    tick();
    chk("lz_dot_seg", {24'h0, bus.segments}, 32'hFE);
    chk("lz_dot_an", {28'h0, bus.anodes}, 32'h7);
    bus.lz_blank = 1'b0;
    run(FR);

    // per-digit enable, then reset during digit 2 with a load pending
    bus.digit_en = 4'b0101;
    run(2 * FR);
    bus.digit_en = 4'hF;
    goto_phase(RD + 2);
    do_load(16'h9876, 4'hF);
    goto_phase(2 * RD + 3);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(2 * FR);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.load  = ($urandom_range(0, 15) == 0);
      bus.value = 16'($urandom);
      bus.dp_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0) bus.digit_en = 4'($urandom);
      if ($urandom_range(0, 63) == 0) bus.lz_blank = 1'($urandom);
      if ($urandom_range(0, 31) == 0) bus.value = 16'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    bus.load = 1'b0;
    rst_n = 1'b1;
    run(FR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
